// File: rtl/fe_fifo_reader_pkg.sv
// Shared front-end FIFO definitions: entry command codes, packet lengths and
// the last-byte index lookup used by the packet encoder.
package fe_fifo_reader_pkg;

  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;
  localparam logic [1:0] FE_FIFO_CMD_RSVD = 2'd3;

  localparam logic [1:0] FE_PKT_LEN_DATA = 2'd2;
  localparam logic [1:0] FE_PKT_LEN_STAT = 2'd1;
  localparam logic [1:0] FE_PKT_LEN_TIME = 2'd3;

  function automatic logic [1:0] fe_pkt_last_idx(input logic [1:0] cmd);
    case (cmd)
      FE_FIFO_CMD_DATA: return FE_PKT_LEN_DATA - 2'd1;
      FE_FIFO_CMD_STAT: return FE_PKT_LEN_STAT - 2'd1;
      FE_FIFO_CMD_TIME: return FE_PKT_LEN_TIME - 2'd1;
      default:          return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fe_fifo_reader_pkt_encoder.sv
// Combinational packet encoder: selects the stream byte for one held FIFO entry
// at a given byte index and flags the last byte and any format error.
module fe_pkt_encoder
  import fe_fifo_reader_pkg::*;
#(
  parameter int TW = 16,
  parameter int SW = 3
) (
  input  logic [1:0]    i_cmd,
  input  logic [TW-1:0] i_time,
  input  logic [7:0]    i_data,
  input  logic [1:0]    i_byte_idx,
  output logic [7:0]    o_byte,
  output logic          o_is_last,
  output logic          o_fmt_err
);

  logic          w_clip;
  logic [SW-1:0] w_short;

  // A DATA timestamp that does not fit the short field saturates to all-ones.
  assign w_clip  = |i_time[TW-1:SW];
  assign w_short = w_clip ? {SW{1'b1}} : i_time[SW-1:0];

  always_comb begin
    o_byte    = 8'h00;
    o_fmt_err = 1'b0;
    o_is_last = (i_byte_idx == fe_pkt_last_idx(i_cmd));
    case (i_cmd)
      FE_FIFO_CMD_DATA: begin
        o_fmt_err = w_clip;
        o_byte    = (i_byte_idx == 2'd0) ? {i_cmd, w_short, {(6-SW){1'b0}}} : i_data;
      end
      FE_FIFO_CMD_STAT: begin
        o_byte = {i_cmd, i_data[5:0]};
      end
      FE_FIFO_CMD_TIME: begin
        case (i_byte_idx)
          2'd0:    o_byte = {i_cmd, 6'b0};
          2'd1:    o_byte = i_time[7:0];
          default: o_byte = i_time[15:8];
        endcase
      end
      default: begin
        o_fmt_err = 1'b1;
        o_byte    = {FE_FIFO_CMD_RSVD, 6'b0};
      end
    endcase
  end

endmodule

// File: rtl/fe_fifo_reader.sv
// Drains the front-end capture FIFO and streams each entry as a 1-3 byte packet.
// First byte valid 2 cycles after O_fifo_rd; the byte is held while I_byte_ready is low.
module fe_fifo_reader
  import fe_fifo_reader_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pCOUNT_WIDTH           = 24
) (
  input  logic                             cwusb_clk,
  input  logic                             reset_n,
  input  logic                             I_enable,
  input  logic                             I_flush,
  input  logic                             I_fifo_empty,
  input  logic [1:0]                       I_fifo_cmd,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_time,
  input  logic [7:0]                       I_fifo_data,
  output logic                             O_fifo_rd,
  output logic [7:0]                       O_byte,
  output logic                             O_byte_valid,
  input  logic                             I_byte_ready,
  output logic                             O_busy,
  output logic [pCOUNT_WIDTH-1:0]          O_entry_count,
  output logic                             O_format_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]                       r_state;
  logic [1:0]                       r_byte_idx;
  logic [1:0]                       r_cmd;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] r_time;
  logic [7:0]                       r_data;
  logic [pCOUNT_WIDTH-1:0]          r_count;
  logic                             r_fmt_err;

  logic       w_pop;
  logic       w_xfer;
  logic       w_last_xfer;
  logic [7:0] w_byte;
  logic       w_is_last;
  logic       w_fmt_err;

  fe_pkt_encoder #(
    .TW (pTIMESTAMP_FULL_WIDTH),
    .SW (pTIMESTAMP_SHORT_WIDTH)
  ) u_enc (
    .i_cmd      (r_cmd),
    .i_time     (r_time),
    .i_data     (r_data),
    .i_byte_idx (r_byte_idx),
    .o_byte     (w_byte),
    .o_is_last  (w_is_last),
    .o_fmt_err  (w_fmt_err)
  );

  assign w_pop       = I_enable & ~I_fifo_empty & ~I_flush;
  assign w_xfer      = (r_state == ST_SEND) & I_byte_ready;
  assign w_last_xfer = w_xfer & w_is_last;

  // Popping on the last transfer lets the next entry land in WAIT with no idle cycle.
  assign O_fifo_rd      = w_pop & ((r_state == ST_IDLE) | w_last_xfer);
  assign O_byte_valid   = (r_state == ST_SEND);
  assign O_byte         = O_byte_valid ? w_byte : 8'h00;
  assign O_busy         = (r_state != ST_IDLE);
  assign O_entry_count  = r_count;
  assign O_format_error = r_fmt_err;

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_byte_idx <= 2'd0;
      r_cmd      <= 2'd0;
      r_time     <= '0;
      r_data     <= 8'h00;
      r_count    <= '0;
      r_fmt_err  <= 1'b0;
    end else if (I_flush) begin
      r_state    <= ST_IDLE;
      r_byte_idx <= 2'd0;
      r_count    <= '0;
      r_fmt_err  <= 1'b0;
    end else begin
      if (O_fifo_rd && (r_count != {pCOUNT_WIDTH{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
      if ((r_state == ST_SEND) && w_fmt_err) begin
        r_fmt_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cmd      <= I_fifo_cmd;
          r_time     <= I_fifo_time;
          r_data     <= I_fifo_data;
          r_byte_idx <= 2'd0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_last_xfer) begin
            r_byte_idx <= 2'd0;
            r_state    <= w_pop ? ST_WAIT : ST_IDLE;
          end else if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Scoreboard bench for fe_fifo_reader: a FIFO model feeds entries, a monitor
// compares every transferred byte and checks latency, stall stability and pop rules.
module tb_fe_fifo_reader;

  logic        cwusb_clk = 1'b0;
  logic        reset_n;
  logic        I_enable;
  logic        I_flush;
  logic        I_fifo_empty;
  logic [1:0]  I_fifo_cmd;
  logic [15:0] I_fifo_time;
  logic [7:0]  I_fifo_data;
  logic        O_fifo_rd;
  logic [7:0]  O_byte;
  logic        O_byte_valid;
  logic        I_byte_ready;
  logic        O_busy;
  logic [23:0] O_entry_count;
  logic        O_format_error;

  fe_fifo_reader dut (
    .cwusb_clk      (cwusb_clk),
    .reset_n        (reset_n),
    .I_enable       (I_enable),
    .I_flush        (I_flush),
    .I_fifo_empty   (I_fifo_empty),
    .I_fifo_cmd     (I_fifo_cmd),
    .I_fifo_time    (I_fifo_time),
    .I_fifo_data    (I_fifo_data),
    .O_fifo_rd      (O_fifo_rd),
    .O_byte         (O_byte),
    .O_byte_valid   (O_byte_valid),
    .I_byte_ready   (I_byte_ready),
    .O_busy         (O_busy),
    .O_entry_count  (O_entry_count),
    .O_format_error (O_format_error)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] t;
    logic [7:0]  d;
  } ent_t;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  ent_t fifo_q[$];
  exp_t exp_q[$];
  int   rd_q[$];

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rd_count = 0;
  int         xfer_count = 0;
  bit         in_pkt = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge cwusb_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    ent_t e;
    e.cmd = c;
    e.t   = t;
    e.d   = d;
    fifo_q.push_back(e);
    I_fifo_empty = 1'b0;
  endtask

  task automatic expb(input logic [7:0] b, input bit last);
    exp_t e;
    e.b    = b;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (O_byte_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_valid_timeout"}, seen, 1);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !O_busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_idle_timeout"}, done, 1);
  endtask

  // Non-FWFT FIFO model: entry appears on the outputs one cycle after the pop.
  initial begin
    bit   rd_s;
    ent_t e;
    forever begin
      @(negedge cwusb_clk);
      rd_s = O_fifo_rd;
      @(posedge cwusb_clk);
      #1;
      if (rd_s && fifo_q.size() > 0) begin
        e = fifo_q.pop_front();
        I_fifo_cmd  = e.cmd;
        I_fifo_time = e.t;
        I_fifo_data = e.d;
      end
      I_fifo_empty = (fifo_q.size() == 0);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge cwusb_clk);
      if (!reset_n) continue;
      cyc++;
      if (I_flush) begin
        exp_q.delete();
        rd_q.delete();
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      if (O_fifo_rd) begin
        rd_count++;
        rd_q.push_back(cyc);
        chk("rd_nonempty", I_fifo_empty, 0);
        if (O_byte_valid) chk("rd_on_last_xfer", I_byte_ready, 1);
      end
      if (prev_stall) begin
        chk("stall_valid", O_byte_valid, 1);
        chk("stall_byte", O_byte, prev_byte);
      end
      if (O_byte_valid && !in_pkt) begin
        in_pkt = 1'b1;
        if (rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_before_valid: packet valid with no prior O_fifo_rd (cycle %0d)", cyc);
        end else begin
          chk("rd_to_valid", cyc - rd_q.pop_front(), 2);
        end
      end
      if (O_byte_valid && I_byte_ready) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h, expected none (cycle %0d)", O_byte, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("byte", O_byte, e.b);
          if (e.last) in_pkt = 1'b0;
        end
      end
      prev_stall = O_byte_valid && !I_byte_ready;
      prev_byte  = O_byte;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rd0;
    int x0;
    reset_n      = 1'b0;
    I_enable     = 1'b0;
    I_flush      = 1'b0;
    I_fifo_empty = 1'b1;
    I_fifo_cmd   = 2'd0;
    I_fifo_time  = 16'h0;
    I_fifo_data  = 8'h0;
    I_byte_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", O_byte_valid, 0);
    chk("rst_rd", O_fifo_rd, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_byte", O_byte, 0);
    chk("rst_count", O_entry_count, 0);
    chk("rst_err", O_format_error, 0);
    reset_n = 1'b1;
    tick();
    I_enable     = 1'b1;
    I_byte_ready = 1'b1;

    // DATA time=5
    push(2'd0, 16'd5, 8'hA7);
    expb(8'h28, 0); expb(8'hA7, 1);
    wait_idle("data");
    chk("data_count", O_entry_count, 1);
    chk("data_err", O_format_error, 0);

    // TIME then STAT back to back
    rd0 = rd_count;
    push(2'd2, 16'h1234, 8'h00);
    push(2'd1, 16'h0000, 8'h3F);
    expb(8'h80, 0); expb(8'h34, 0); expb(8'h12, 1);
    expb(8'h7F, 1);
    wait_idle("b2b");
    chk("b2b_rds", rd_count - rd0, 2);
    chk("b2b_count", O_entry_count, 3);

    // Backpressure during TIME packet: ready 1-0-0-1
    rd0 = rd_count;
    x0  = xfer_count;
    I_byte_ready = 1'b0;
    push(2'd2, 16'hBEEF, 8'h00);
    expb(8'h80, 0); expb(8'hEF, 0); expb(8'hBE, 1);
    wait_valid("bp");
    I_byte_ready = 1'b1; tick();
    I_byte_ready = 1'b0; tick();
    tick();
    I_byte_ready = 1'b1;
    wait_idle("bp");
    chk("bp_rds", rd_count - rd0, 1);
    chk("bp_xfers", xfer_count - x0, 3);
    chk("bp_count", O_entry_count, 4);

    // Oversized DATA time, then reserved command
    push(2'd0, 16'd9, 8'h01);
    expb(8'h38, 0); expb(8'h01, 1);
    wait_idle("clip");
    chk("clip_err", O_format_error, 1);
    push(2'd3, 16'h0000, 8'h00);
    expb(8'hC0, 1);
    wait_idle("rsvd");
    chk("rsvd_err", O_format_error, 1);
    chk("rsvd_count", O_entry_count, 6);

    // Flush while in WAIT
    push(2'd0, 16'd1, 8'h11);
    tick();
    chk("wait_busy", O_busy, 1);
    chk("wait_novalid", O_byte_valid, 0);
    I_flush = 1'b1; tick(); I_flush = 1'b0;
    chk("flw_valid", O_byte_valid, 0);
    chk("flw_busy", O_busy, 0);
    chk("flw_count", O_entry_count, 0);
    chk("flw_err", O_format_error, 0);

    // Flush mid-SEND, then a clean entry
    I_byte_ready = 1'b0;
    push(2'd2, 16'h5566, 8'h00);
    expb(8'h80, 0);
    wait_valid("fls");
    I_byte_ready = 1'b1; tick();
    I_byte_ready = 1'b0;
    I_flush = 1'b1; tick(); I_flush = 1'b0;
    chk("fls_valid", O_byte_valid, 0);
    chk("fls_count", O_entry_count, 0);
    I_byte_ready = 1'b1;
    push(2'd0, 16'd3, 8'h55);
    expb(8'h18, 0); expb(8'h55, 1);
    wait_idle("post_flush");
    chk("pf_count", O_entry_count, 1);

    // Enable dropped mid-packet with 4 queued
    rd0 = rd_count;
    x0  = xfer_count;
    I_byte_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(2'd1, 16'h0, 8'(i));
      expb(8'h40 | 8'(i), 1);
    end
    wait_valid("en");
    I_enable     = 1'b0;
    I_byte_ready = 1'b1;
    repeat (10) tick();
    chk("en_rds", rd_count - rd0, 1);
    chk("en_xfers", xfer_count - x0, 1);
    chk("en_busy", O_busy, 0);
    chk("en_left", fifo_q.size(), 3);
    I_enable = 1'b1;
    wait_idle("en");
    chk("en_rds_all", rd_count - rd0, 4);
    chk("en_count", O_entry_count, 5);

    // Empty FIFO: no pops
    rd0 = rd_count;
    repeat (20) tick();
    chk("empty_rds", rd_count - rd0, 0);
    chk("empty_busy", O_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fe_fifo_reader.md
Name: fe_fifo_reader

Overview:
Drain side of the front-end capture FIFO, in the cwusb_clk domain. The block pops entries {cmd, time, data} written by the front-end capture logic. It encodes each entry into a 1-3 byte packet and presents the packets as a valid/ready byte stream to the USB register-read path. It also keeps an entry counter and a sticky format-error flag for software.

Parameters:
pTIMESTAMP_FULL_WIDTH, 16, width of the time field in a FIFO entry; must be 16.
pTIMESTAMP_SHORT_WIDTH, 3, width of the short timestamp carried in a DATA header.
pCOUNT_WIDTH, 24, width of O_entry_count.

Ports:
cwusb_clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
I_enable  in  1  permits new FIFO reads.
I_flush  in  1  synchronous abort and clear.
I_fifo_empty  in  1  FIFO empty.
I_fifo_cmd  in  2  entry command.
I_fifo_time  in  16  entry time.
I_fifo_data  in  8  entry data byte.
O_fifo_rd  out  1  FIFO pop; data is valid one cycle later (standard, non-FWFT FIFO).
O_byte  out  8  stream byte.
O_byte_valid  out  1  stream valid.
I_byte_ready  in  1  stream ready.
O_busy  out  1  asserted when state != IDLE.
O_entry_count  out  pCOUNT_WIDTH  number of entries popped since the last flush; saturates at all-ones.
O_format_error  out  1  sticky; cleared only by flush.

Behaviour:
- Reset: all outputs 0. State IDLE. Byte index 0.
- Command encodings come from the shared defines: FE_FIFO_CMD_DATA=2'd0, FE_FIFO_CMD_STAT=2'd1, FE_FIFO_CMD_TIME=2'd2. Value 2'd3 is reserved.
- Packet formats (header byte is always sent first):
  - DATA: 2 bytes. Header = {cmd, time[2:0], 3'b000}, then data.
  - STAT: 1 byte. Header = {cmd, data[5:0]}.
  - TIME: 3 bytes. Header = {cmd, 6'b0}, then time[7:0], then time[15:8].
  - Reserved (2'd3): 1 byte, {2'b11, 6'b0}. Sets O_format_error.
- If a DATA entry has time > 7: time is clipped to 3'b111 and O_format_error is set.
- FSM states: IDLE, WAIT, SEND.
  - IDLE -> WAIT when pop = I_enable & ~I_fifo_empty & ~I_flush.
  - WAIT: captures the entry into holding registers. Always -> SEND next cycle.
  - SEND: O_byte_valid=1; O_byte is driven from the holding registers and the byte index.
  - A byte transfers on O_byte_valid & I_byte_ready; the byte index increments on each transfer.
  - After the last byte transfers: -> WAIT if pop, else -> IDLE.
- O_fifo_rd is combinational: pop & (state==IDLE | (state==SEND & last byte transferring)).
  - It is never asserted while I_fifo_empty=1.
  - It is asserted at most once per packet.
- Latency: first byte is valid 2 cycles after O_fifo_rd. With I_byte_ready held high, sustained throughput is one packet per (bytes + 1) cycles.
- Stream rule: O_byte is stable while O_byte_valid=1 and I_byte_ready=0. Valid never drops without a transfer, except on flush or reset.
- I_enable=0 mid-packet: the current packet completes; no new pop is issued.
- I_flush=1 in any state:
  - Next cycle: IDLE, O_byte_valid=0, byte index 0, count 0, error 0.
  - An entry being read in WAIT is discarded.
  - Flush takes priority over a simultaneous transfer or pop.
- O_entry_count increments in the same cycle O_fifo_rd is asserted.
- Asynchronous reset mid-packet: the partial packet is lost. The FIFO is not re-read.

Decomposition:
- Add the FE_FIFO_CMD_* constants and the packet byte lengths (DATA=2, STAT=1, TIME=3) to the shared defines_pw.v.
- One natural sub-module: fe_pkt_encoder. It is combinational and maps {cmd, time, data, byte_idx} to {byte, is_last, fmt_err}. The FSM, holding registers and counters stay in fe_fifo_reader.

Test Plan:
- DATA entry cmd=0, time=5, data=0xA7, ready=1 -> stream 0x28, 0xA7; O_entry_count=1; rd-to-first-valid = 2 cycles.
- TIME entry cmd=2, time=0x1234, followed by STAT cmd=1, data=0x3F with FIFO non-empty -> 0x80, 0x34, 0x12, 0x7F. Second O_fifo_rd coincides with the 0x12 transfer; no idle gap beyond the WAIT cycle.
- Backpressure: ready toggled 1-0-0-1 during a TIME packet -> O_byte held constant across the stalls; exactly 3 transfers; a single O_fifo_rd.
- DATA cmd=0, time=9, data=0x01 -> 0x38, 0x01; O_format_error=1 and stays set. Reserved cmd=3 -> 0xC0.
- I_flush pulsed in WAIT and mid-SEND -> valid low next cycle, count=0, error=0. A subsequent entry is encoded correctly from byte 0.
- I_enable dropped mid-packet with 4 entries queued -> current packet finishes; no further O_fifo_rd until enable returns. Empty FIFO -> O_fifo_rd never asserted.
